// File: rtl/upload_pkg.sv
// ============================================================================
//  Module      : upload_pkg
//  Description : Shared constants, state encoding and checksum helper for the
//                upload packer (frame: HDR0 HDR1 SRC LEN_H LEN_L payload CHK).
//  Contents    : header defaults, source codes, frame overhead, FSM encoding,
//                frame_chk() helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package upload_pkg;

    // Default sync bytes opening every frame.
    localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT = 8'h44;

    // Source/command codes carried in the SRC byte.
    localparam logic [7:0] SRC_CONFIG = 8'h04;
    localparam logic [7:0] SRC_WRITE  = 8'h05;
    localparam logic [7:0] SRC_READ   = 8'h06;

    // Non-payload bytes per frame: HDR0, HDR1, SRC, LEN_H, LEN_L, CHK.
    localparam int FRAME_OVERHEAD = 6;

    // State encoding.
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_COLLECT = 4'd1;
    localparam logic [3:0] ST_HDR0    = 4'd2;
    localparam logic [3:0] ST_HDR1    = 4'd3;
    localparam logic [3:0] ST_SRC     = 4'd4;
    localparam logic [3:0] ST_LENH    = 4'd5;
    localparam logic [3:0] ST_LENL    = 4'd6;
    localparam logic [3:0] ST_PAYLOAD = 4'd7;
    localparam logic [3:0] ST_CHK     = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_COLLECT = ST_COLLECT,
        S_HDR0    = ST_HDR0,
        S_HDR1    = ST_HDR1,
        S_SRC     = ST_SRC,
        S_LENH    = ST_LENH,
        S_LENL    = ST_LENL,
        S_PAYLOAD = ST_PAYLOAD,
        S_CHK     = ST_CHK
    } pk_state_e;

    // Trailing checksum: SRC + LEN_H + LEN_L + payload sum, modulo 256.
    function automatic logic [7:0] frame_chk(input logic [7:0]  src,
                                             input logic [15:0] len,
                                             input logic [7:0]  psum);
        return src + len[15:8] + len[7:0] + psum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/upload_packer_if.sv
// ============================================================================
//  Module      : upload_packer_if
//  Description : Upload-side and packet-side handshake bundle of the packer.
//  Modports    : slave  - packer view (consumes upload, produces packets)
//                master - producer/host view (drives upload, sinks packets)
//  Signals     : upload_req/data/source/valid/ready, pack_data/valid/ready,
//                pack_busy
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface upload_packer_if;

    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] pack_data;
    logic       pack_valid;
    logic       pack_ready;
    logic       pack_busy;

    modport slave (
        input  upload_req,
        input  upload_data,
        input  upload_source,
        input  upload_valid,
        output upload_ready,
        output pack_data,
        output pack_valid,
        input  pack_ready,
        output pack_busy
    );

    modport master (
        output upload_req,
        output upload_data,
        output upload_source,
        output upload_valid,
        input  upload_ready,
        input  pack_data,
        input  pack_valid,
        output pack_ready,
        input  pack_busy
    );

endinterface

`default_nettype wire

// File: rtl/upload_byte_fifo.sv
// ============================================================================
//  Module      : upload_byte_fifo
//  Description : Synchronous first-word-fall-through byte FIFO; dout shows the
//                head entry whenever the FIFO is not empty.
//  Ports       : clk, rst_n (async, active-low), push/din, pop/dout,
//                empty, full, count (occupancy, 0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module upload_byte_fifo #(
    parameter int DEPTH = 256
) (
    input  wire                       clk,
    input  wire                       rst_n,
    input  wire                       push,
    input  wire  [7:0]                din,
    input  wire                       pop,
    output logic [7:0]                dout,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop  && !empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/upload_packer.sv
// ============================================================================
//  Module      : upload_packer
//  Description : Buffers one upload burst in a byte FIFO and emits it as a
//                framed packet: HDR0 HDR1 SRC LEN_H LEN_L payload CHK.
//  Ports       : clk, rst_n (async, active-low),
//                bus (upload_packer_if.slave): upload_req/data/source/valid,
//                upload_ready, pack_data/valid/ready, pack_busy
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module upload_packer
    import upload_pkg::*;
#(
    parameter int         FIFO_DEPTH = 256,
    parameter logic [7:0] HDR0       = HDR0_DEFAULT,
    parameter logic [7:0] HDR1       = HDR1_DEFAULT
) (
    input  wire             clk,
    input  wire             rst_n,
    upload_packer_if.slave  bus
);

    localparam logic [15:0] DEPTH16 = 16'(FIFO_DEPTH);

    pk_state_e   state_q;
    logic [7:0]  src_q;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [7:0]  csum_q;
    logic [7:0]  pack_data_q;
    logic        pack_valid_q;

    logic        byte_accept;
    logic        pack_fire;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign bus.upload_ready = (state_q == S_COLLECT) && (count_q < DEPTH16);
    assign byte_accept      = bus.upload_valid && bus.upload_ready;
    assign count_d          = count_q + {15'd0, byte_accept};
    assign pack_fire        = pack_valid_q && bus.pack_ready;

    // Payload is prefetched: each FIFO head is popped at the moment it is
    // loaded into the output register, so the FIFO runs dry exactly when the
    // last payload byte is on the output.
    assign fifo_pop = pack_fire &&
                      ((state_q == S_LENL) ||
                       ((state_q == S_PAYLOAD) && !fifo_empty));

    upload_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (byte_accept && !fifo_full),
        .din   (bus.upload_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= 8'h00;
            count_q      <= 16'd0;
            csum_q       <= 8'h00;
            pack_data_q  <= 8'h00;
            pack_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.upload_req) begin
                        state_q <= S_COLLECT;
                        src_q   <= bus.upload_source;
                        count_q <= 16'd0;
                        csum_q  <= 8'h00;
                    end
                end

                S_COLLECT: begin
                    if (byte_accept) begin
                        count_q <= count_d;
                        csum_q  <= csum_q + bus.upload_data;
                    end
                    // Close decisions use the post-acceptance count.
                    if (count_d == DEPTH16) begin
                        state_q      <= S_HDR0;
                        pack_data_q  <= HDR0;
                        pack_valid_q <= 1'b1;
                    end else if (!bus.upload_req) begin
                        if (count_d != 16'd0) begin
                            state_q      <= S_HDR0;
                            pack_data_q  <= HDR0;
                            pack_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_HDR0: begin
                    if (pack_fire) begin
                        state_q     <= S_HDR1;
                        pack_data_q <= HDR1;
                    end
                end

                S_HDR1: begin
                    if (pack_fire) begin
                        state_q     <= S_SRC;
                        pack_data_q <= src_q;
                    end
                end

                S_SRC: begin
                    if (pack_fire) begin
                        state_q     <= S_LENH;
                        pack_data_q <= count_q[15:8];
                    end
                end

                S_LENH: begin
                    if (pack_fire) begin
                        state_q     <= S_LENL;
                        pack_data_q <= count_q[7:0];
                    end
                end

                S_LENL: begin
                    if (pack_fire) begin
                        state_q     <= S_PAYLOAD;
                        pack_data_q <= fifo_dout;
                    end
                end

                S_PAYLOAD: begin
                    if (pack_fire) begin
                        if (fifo_count == '0) begin
                            state_q     <= S_CHK;
                            pack_data_q <= frame_chk(src_q, count_q, csum_q);
                        end else begin
                            pack_data_q <= fifo_dout;
                        end
                    end
                end

                S_CHK: begin
                    if (pack_fire) begin
                        pack_valid_q <= 1'b0;
                        pack_data_q  <= 8'h00;
                        if (bus.upload_req) begin
                            // Continuation frame keeps the latched source.
                            state_q <= S_COLLECT;
                            count_q <= 16'd0;
                            csum_q  <= 8'h00;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_q      <= S_IDLE;
                    pack_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pack_data  = pack_data_q;
    assign bus.pack_valid = pack_valid_q;
    assign bus.pack_busy  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_upload_packer.sv
// ============================================================================
//  Module      : tb_upload_packer
//  Description : Directed self-checking bench for upload_packer; a 256-deep
//                instance (u_a) and a 4-deep instance (u_b) share stimulus,
//                selected by sel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_upload_packer;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [7:0] data;
    logic [7:0] src;
    logic       valid;
    logic       pready;
    logic       sel;
    logic       bp_en;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;

    logic [7:0] q[$];
    int         tq[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    upload_packer_if bus_a ();
    upload_packer_if bus_b ();

    assign bus_a.upload_req    = req & ~sel;
    assign bus_a.upload_valid  = valid & ~sel;
    assign bus_a.upload_data   = data;
    assign bus_a.upload_source = src;
    assign bus_a.pack_ready    = pready;

    assign bus_b.upload_req    = req & sel;
    assign bus_b.upload_valid  = valid & sel;
    assign bus_b.upload_data   = data;
    assign bus_b.upload_source = src;
    assign bus_b.pack_ready    = pready;

    upload_packer #(.FIFO_DEPTH(256)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    upload_packer #(.FIFO_DEPTH(4))   u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic       w_ready, w_pvalid, w_busy;
    logic [7:0] w_pdata;
    assign w_ready  = sel ? bus_b.upload_ready : bus_a.upload_ready;
    assign w_pvalid = sel ? bus_b.pack_valid   : bus_a.pack_valid;
    assign w_pdata  = sel ? bus_b.pack_data    : bus_a.pack_data;
    assign w_busy   = sel ? bus_b.pack_busy    : bus_a.pack_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: captures accepted bytes, checks hold-while-stalled and
    // that no byte is ever accepted into a full FIFO.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_hold_data", 32'(w_pdata), 32'(prev_data));
                chk("stall_hold_valid", 32'(w_pvalid), 32'd1);
            end
            if (w_pvalid && pready) begin
                q.push_back(w_pdata);
                tq.push_back(cyc);
            end
            if (u_a.byte_accept) chk("a_no_overflow", 32'(u_a.fifo_full), 32'd0);
            if (u_b.byte_accept) chk("b_no_overflow", 32'(u_b.fifo_full), 32'd0);
            prev_stall = w_pvalid && !pready;
            prev_data  = w_pdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) pready = 1'($urandom_range(0, 1));
    endtask

    // Offer one byte and hold it until accepted; returns cycles spent waiting.
    task automatic put(input logic [7:0] b, output int waited);
        valid  = 1'b1;
        data   = b;
        waited = 0;
        while (!w_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!w_ready) begin
            n_checks++;
            n_err++;
            $error("FAIL put_timeout: observed=ready_low expected=accept byte %0h", b);
        end
        tick();
    endtask

    task automatic wait_bytes(input int n, input int limit);
        int k = 0;
        while (q.size() < n && k < limit) begin
            tick();
            k++;
        end
        chk("wait_bytes_count", 32'(q.size()), 32'(n));
    endtask

    task automatic check_frame(input string tag, input logic [7:0] e[$]);
        chk({tag, "_len"}, 32'(q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < q.size()) chk($sformatf("%s[%0d]", tag, i), 32'(q[i]), 32'(e[i]));
        end
    endtask

    // Burst 11 22 33 from source 06 on the 256-deep instance.
    task automatic scenario1(input string tag);
        int w;
        logic [7:0] e[$];
        src = 8'h06;
        req = 1'b1;
        tick();
        put(8'h11, w);
        put(8'h22, w);
        put(8'h33, w);
        valid = 1'b0;
        req   = 1'b0;
        tick();
        chk({tag, "_hdr0_valid"}, 32'(w_pvalid), 32'd1);
        chk({tag, "_hdr0_data"}, 32'(w_pdata), 32'hAA);
        wait_bytes(9, 80);
        e = '{8'hAA, 8'h44, 8'h06, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6F};
        check_frame(tag, e);
        chk({tag, "_busy_after_chk"}, 32'(w_busy), 32'd0);
        chk({tag, "_valid_after_chk"}, 32'(w_pvalid), 32'd0);
    endtask

    initial begin
        int w;
        int bad;
        logic [7:0] e[$];

        rst_n  = 1'b0;
        req    = 1'b0;
        data   = 8'h00;
        src    = 8'h00;
        valid  = 1'b0;
        pready = 1'b1;
        sel    = 1'b0;
        bp_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        chk("rst_upload_ready", 32'(bus_a.upload_ready), 32'd0);
        chk("rst_pack_valid", 32'(bus_a.pack_valid), 32'd0);
        chk("rst_pack_data", 32'(bus_a.pack_data), 32'h00);
        chk("rst_pack_busy", 32'(bus_a.pack_busy), 32'd0);
        chk("rst_b_pack_busy", 32'(bus_b.pack_busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single burst, no backpressure, zero bubbles
        q.delete(); tq.delete();
        scenario1("t1");
        if (tq.size() >= 9) chk("t1_no_bubbles", 32'(tq[8] - tq[0]), 32'd8);

        // Empty burst: request pulse without data
        q.delete(); tq.delete();
        src = 8'h06;
        req = 1'b1;
        tick();
        chk("t2_ready_collect", 32'(w_ready), 32'd1);
        chk("t2_busy_collect", 32'(w_busy), 32'd1);
        req = 1'b0;
        tick();
        chk("t2_ready_idle", 32'(w_ready), 32'd0);
        chk("t2_busy_idle", 32'(w_busy), 32'd0);
        repeat (5) tick();
        chk("t2_no_output", 32'(q.size()), 32'd0);
        chk("t2_pack_valid", 32'(w_pvalid), 32'd0);

        // Depth-4 instance: close-by-full then continuation frame
        sel = 1'b1;
        q.delete(); tq.delete();
        src = 8'h06;
        req = 1'b1;
        tick();
        for (int b = 1; b <= 4; b++) put(8'(b), w);
        chk("t3_ready_emit", 32'(w_ready), 32'd0);
        chk("t3_hdr0_valid", 32'(w_pvalid), 32'd1);
        put(8'h05, w);
        chk("t3_byte5_wait", 32'(w), 32'd10);
        put(8'h06, w);
        valid = 1'b0;
        req   = 1'b0;
        tick();
        wait_bytes(18, 80);
        e = '{8'hAA, 8'h44, 8'h06, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14,
              8'hAA, 8'h44, 8'h06, 8'h00, 8'h02, 8'h05, 8'h06, 8'h13};
        check_frame("t3", e);
        chk("t3_busy_end", 32'(w_busy), 32'd0);
        sel = 1'b0;
        tick();

        // Random backpressure on the first scenario
        q.delete(); tq.delete();
        bp_en = 1'b1;
        scenario1("t4");
        bp_en  = 1'b0;
        pready = 1'b1;
        tick();

        // 256 x FF: close by full, LEN = 0x0100
        q.delete(); tq.delete();
        src = 8'h06;
        req = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) put(8'hFF, w);
        valid = 1'b0;
        req   = 1'b0;
        tick();
        wait_bytes(262, 600);
        if (q.size() == 262) begin
            chk("t5_src", 32'(q[2]), 32'h06);
            chk("t5_lenh", 32'(q[3]), 32'h01);
            chk("t5_lenl", 32'(q[4]), 32'h00);
            chk("t5_chk", 32'(q[261]), 32'h07);
            bad = 0;
            for (int i = 5; i < 261; i++) if (q[i] !== 8'hFF) bad++;
            chk("t5_payload_ff", 32'(bad), 32'd0);
            chk("t5_no_bubbles", 32'(tq[261] - tq[0]), 32'd261);
        end

        // Asynchronous reset during payload, then a clean frame
        q.delete(); tq.delete();
        src = 8'h06;
        req = 1'b1;
        tick();
        put(8'h11, w);
        put(8'h22, w);
        put(8'h33, w);
        valid = 1'b0;
        req   = 1'b0;
        tick();
        wait_bytes(6, 30);
        chk("t6_in_payload", 32'(w_pdata), 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus_a.pack_valid), 32'd0);
        chk("t6_rst_busy", 32'(bus_a.pack_busy), 32'd0);
        chk("t6_rst_data", 32'(bus_a.pack_data), 32'h00);
        chk("t6_rst_fifo_empty", 32'(u_a.fifo_empty), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_partial", 32'(q.size()), 32'd6);
        q.delete(); tq.delete();
        src = 8'h05;
        req = 1'b1;
        tick();
        put(8'hAB, w);
        valid = 1'b0;
        req   = 1'b0;
        tick();
        wait_bytes(7, 30);
        e = '{8'hAA, 8'h44, 8'h05, 8'h00, 8'h01, 8'hAB, 8'hB1};
        check_frame("t6", e);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
